// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles little-endian words, writes them to imem
// sequentially, and holds the core in reset until the frame checksum verifies.
module imem_loader #(
  parameter int MEM_DEPTH_WORDS = 4096,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  logic [23:0]        part_q, part_d;
  logic [7:0]         csum_q, csum_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;

  logic               xfer;
  logic [CNT_W-1:0]   len_new;
  logic [31:0]        len_ext;

  assign busy       = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CHECK);
  assign byte_ready = busy;
  assign xfer       = byte_valid && byte_ready;
  assign cpu_rst_n  = (state_q == IDLE) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

  // Full word count as it becomes known on the LEN_HI byte.
  assign len_new = CNT_W'({byte_data, len_q[7:0]});
  assign len_ext = 32'(len_new);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      part_q    <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      part_q    <= part_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    part_d    = part_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_LO;
          idx_d   = '0;
          lane_d  = '0;
          csum_d  = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d   = CNT_W'(byte_data);
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d = len_new;
          if (len_ext > 32'(MEM_DEPTH_WORDS)) begin
            state_d = ERR;
          end else if (len_new == '0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ byte_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: part_d[7:0]   = byte_data;
            2'd1: part_d[15:8]  = byte_data;
            2'd2: part_d[23:16] = byte_data;
            default: begin
              // Lane 3 completes the word; it is written on the following cycle.
              wr_en_d   = 1'b1;
              wr_data_d = {byte_data, part_q};
              wr_addr_d = 32'({idx_q, 2'b00});
              idx_d     = idx_q + CNT_W'(1);
              if (idx_q == len_q - CNT_W'(1)) begin
                state_d = CHECK;
              end
            end
          endcase
        end
      end
      CHECK: begin
        if (xfer) begin
          state_d = (byte_data == csum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed checks of imem_loader against a frame-level reference model.
module tb_imem_loader;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.MEM_DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: each write records the running transfer count and whether
  // a byte transferred on the very edge that raised wr_en.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          xcnt;
    bit          lat_ok;
  } wr_t;

  wr_t wq[$];
  int  xfer_cnt       = 0;
  int  last_xfer_edge = -10;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, xfer_cnt, (last_xfer_edge == cyc)});
    if (byte_valid && byte_ready === 1'b1) begin
      xfer_cnt       = xfer_cnt + 1;
      last_xfer_edge = cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_idle, input bit with_start);
    int idle;
    int tries;
    idle = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
    repeat (idle) begin
      byte_data = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    tries      = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && tries < 20) begin
      tries++;
      @(negedge clk);
    end
    if (byte_ready !== 1'b1) chk("byte_ready timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  // Reference: word count, writes and verdict derived from the frame bytes alone.
  task automatic run_frame(input string tag, input logic [7:0] fb[$], input int max_idle,
                           input int start_at);
    int          n;
    int          nw;
    int          nsend;
    int          base;
    logic [7:0]  x;
    bit          exp_ok;
    logic [31:0] exp_data;
    n = int'({fb[1], fb[0]});
    if (n > DEPTH) begin
      nw     = 0;
      nsend  = 2;
      exp_ok = 1'b0;
    end else begin
      nw    = n;
      nsend = 2 + 4 * n + 1;
      x     = 8'h00;
      for (int i = 2; i < nsend - 1; i++) x ^= fb[i];
      exp_ok = (fb[nsend - 1] == x);
    end
    base = xfer_cnt;
    wq.delete();

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, " start cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    chk({tag, " start busy"},      {31'd0, busy},      32'd1);
    chk({tag, " start done"},      {31'd0, done},      32'd0);
    chk({tag, " start error"},     {31'd0, error},     32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < nsend; i++) send_byte(fb[i], max_idle, (i == start_at));
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);

    chk({tag, " write count"}, 32'(wq.size()), 32'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      exp_data = {fb[4*i+5], fb[4*i+4], fb[4*i+3], fb[4*i+2]};
      chk($sformatf("%s addr%0d", tag, i),   wq[i].addr, 32'(i * 4));
      chk($sformatf("%s data%0d", tag, i),   wq[i].data, exp_data);
      chk($sformatf("%s xcnt%0d", tag, i),   32'(wq[i].xcnt - base), 32'(4 * i + 6));
      chk($sformatf("%s lat%0d", tag, i),    {31'd0, wq[i].lat_ok}, 32'd1);
    end
    chk({tag, " done"},      {31'd0, done},      {31'd0, exp_ok});
    chk({tag, " error"},     {31'd0, error},     {31'd0, !exp_ok});
    chk({tag, " cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, exp_ok});
    chk({tag, " busy"},      {31'd0, busy},      32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] two[$];
    logic [7:0] fr[$];
    logic [7:0] x;
    int         n;

    two = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'ha0, 8'h00, 8'h20};

    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("reset wr_en",      {31'd0, wr_en},      32'd0);
    chk("reset wr_addr",    wr_addr,             32'd0);
    chk("reset wr_data",    wr_data,             32'd0);
    chk("reset cpu_rst_n",  {31'd0, cpu_rst_n},  32'd1);
    chk("reset busy",       {31'd0, busy},       32'd0);
    chk("reset done",       {31'd0, done},       32'd0);
    chk("reset error",      {31'd0, error},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("two_word", two, 0, -1);
    chk("two_word const data1", (wq.size() > 1) ? wq[1].data : 32'hxxxxxxxx, 32'h00a00093);
    chk("two_word const addr1", (wq.size() > 1) ? wq[1].addr : 32'hxxxxxxxx, 32'h00000004);

    run_frame("backpressure", two, 5, -1);

    fr = two;
    fr[10] = 8'h21;
    run_frame("bad_csum", fr, 3, -1);
    run_frame("after_err", two, 2, -1);

    fr = '{8'h01, 8'h10};
    run_frame("oversize", fr, 1, -1);
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", fr, 1, -1);
    fr = '{8'h00, 8'h00, 8'h05};
    run_frame("empty_bad", fr, 1, -1);

    run_frame("start_busy", two, 2, 1);
    run_frame("start_last", two, 2, 10);
    chk("start_last stays done", {31'd0, done}, 32'd1);

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(6, 1));
      fr = '{};
      fr.push_back(8'(n));
      fr.push_back(8'h00);
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        fr.push_back(8'($urandom));
        x ^= fr[fr.size() - 1];
      end
      if ($urandom_range(3, 0) == 0) x ^= 8'(1 << $urandom_range(7, 0));
      fr.push_back(x);
      run_frame($sformatf("rand%0d", k), fr, 4, -1);
    end

    // Abandon a load after its sixth byte (one word already written).
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(two[i], 1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("midrst wr_en",      {31'd0, wr_en},      32'd0);
    chk("midrst wr_addr",    wr_addr,             32'd0);
    chk("midrst wr_data",    wr_data,             32'd0);
    chk("midrst cpu_rst_n",  {31'd0, cpu_rst_n},  32'd1);
    chk("midrst busy",       {31'd0, busy},       32'd0);
    chk("midrst done",       {31'd0, done},       32'd0);
    chk("midrst error",      {31'd0, error},      32'd0);
    @(posedge clk); #1;
    run_frame("after_rst", two, 1, -1);

    fr = '{};
    fr.push_back(8'(DEPTH & 8'hff));
    fr.push_back(8'(DEPTH >> 8));
    x = 8'h00;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      fr.push_back(8'($urandom));
      x ^= fr[fr.size() - 1];
    end
    fr.push_back(x);
    run_frame("full_depth", fr, 0, -1);
    chk("full_depth last addr",
        (wq.size() == DEPTH) ? wq[DEPTH - 1].addr : 32'hxxxxxxxx, 32'((DEPTH - 1) << 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream writer that programs the instruction memory before the core runs. It takes a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It drives the imem write port with sequential word writes. It holds the core in reset from load start until a checksum-verified load completes.

Parameters:
MEM_DEPTH_WORDS, 4096, imem capacity in words; a frame word count above this is rejected.
CNT_W, 16, width of the frame word-count field and internal word counter.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  one-cycle pulse that begins frame reception; ignored while busy.
byte_valid  input  1  upstream byte available.
byte_data  input  8  upstream byte.
byte_ready  output  1  loader accepts byte_data this cycle when byte_valid is also high.
wr_en  output  1  imem write strobe, one cycle per word.
wr_addr  output  32  imem byte address, always word-aligned (bits [1:0] = 0).
wr_data  output  32  assembled instruction word.
cpu_rst_n  output  1  active-low reset to the core; low while loading or after an error.
busy  output  1  high in LEN_LO, LEN_HI, DATA, CHECK.
done  output  1  level; high in DONE until the next start.
error  output  1  level; high in ERR until the next start.

Behaviour:
- Reset: state IDLE. byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst_n=1, busy=0, done=0, error=0. Counters and checksum are 0. Reset mid-frame abandons the load immediately. Words already written remain in imem.
- Frame format, bytes in order:
  - LEN_LO, LEN_HI: word count N, little-endian.
  - N×4 data bytes: each word is byte0 first, so wr_data = {b3,b2,b1,b0}.
  - One checksum byte: XOR of all data bytes. It is 0x00 when N=0.
- Handshake: a byte transfers when byte_valid && byte_ready at a rising edge. byte_ready=1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 otherwise. byte_data is ignored when no transfer occurs, and stalls of any length are allowed.
- FSM:
  - IDLE/DONE/ERR --start--> LEN_LO. On this edge: cpu_rst_n=0, done=0, error=0, word index=0, byte lane=0, checksum=0.
  - LEN_LO --xfer--> LEN_HI.
  - LEN_HI --xfer--> one of:
    - ERR if N > MEM_DEPTH_WORDS;
    - CHECK if N == 0;
    - DATA otherwise.
  - DATA: each transfer stores the byte into lane (0..3), XORs it into the checksum and increments the lane.
    - On the lane-3 transfer: the next cycle has wr_en=1, wr_data = assembled word, wr_addr = word_index<<2. word_index then increments.
    - When the last word's lane-3 byte is taken, the next state is CHECK.
    - Write latency is exactly 1 cycle after the 4th byte. wr_en is never high for two consecutive cycles without four new transfers.
  - CHECK --xfer--> DONE if the byte equals the checksum, else ERR.
  - DONE: cpu_rst_n=1, done=1.
  - ERR: cpu_rst_n stays 0, error=1.
- start is ignored while busy=1.
- wr_addr and wr_data hold their last values when wr_en=0.
- N = MEM_DEPTH_WORDS is legal; the last wr_addr = (MEM_DEPTH_WORDS-1)<<2 and the index does not wrap.
- start may assert in the same cycle as the final CHECK transfer. Because busy=1 in that cycle, the start is ignored.

Test Plan:
- Two-word load: start, then bytes 02 00 13 00 00 00 93 00 a0 00 20. Required: exactly two wr_en pulses, (addr 0x0, data 0x00000013) then (addr 0x4, data 0x00a00093). done=1, cpu_rst_n=1, error=0.
- Backpressure: same frame with byte_valid toggled randomly (0–5 idle cycles between bytes). Required: identical writes and result. Each wr_en comes exactly 1 cycle after the 4th byte of its word.
- Bad checksum: same frame with last byte 0x21. Required: both writes occur, then error=1, done=0, cpu_rst_n stays 0. A new start clears error and restarts at LEN_LO.
- Oversize and empty: LEN = 0x1001 with MEM_DEPTH_WORDS=4096 gives ERR after LEN_HI with no wr_en. A frame of 00 00 00 gives DONE with no wr_en. A frame of 00 00 05 gives ERR.
- Reset mid-load: rst_n=0 for one cycle after the 6th byte of the two-word frame. Required: all outputs at reset values and state IDLE. A subsequent full frame loads correctly.
- Start during busy: pulse start again after LEN_LO. Required: ignored and the frame completes normally. A start in DONE re-enters LEN_LO and drops cpu_rst_n to 0 on that edge.
